// File: rtl/frogger_pkg.sv
// Shared geometry, palette and lane typedef for the Frogger pixel renderer.
package frogger_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int LANE_H    = 60;
    localparam int NUM_LANES = 8;
    localparam int NUM_ROAD  = 6;
    localparam int CAR_W     = 64;
    localparam int FROG_W    = 32;

    // Vertical margins inside a lane where car / frog sprites are drawn.
    localparam int CAR_TOP   = 10;
    localparam int CAR_BOT   = 49;
    localparam int FROG_TOP  = 14;
    localparam int FROG_BOT  = 45;

    localparam logic [2:0] COL_FROG = 3'b110;
    localparam logic [2:0] COL_CAR  = 3'b100;
    localparam logic [2:0] COL_SAFE = 3'b010;
    localparam logic [2:0] COL_ROAD = 3'b000;

    typedef logic [2:0] lane_t;

    function automatic logic is_road(input lane_t l);
        return (l != 3'd0) && (l != 3'd7);
    endfunction

endpackage

// File: rtl/frogger_renderer_lane_car_hit.sv
// Wrap-aware car overlap test for one lane: distance from the car's left edge, modulo the line width.
module lane_car_hit
    import frogger_pkg::*;
(
    input  logic [9:0] x_i,
    input  logic [9:0] car_x_i,
    input  logic [8:0] row_off_i,
    output logic       hit_o
);

    logic [10:0] c;
    logic [10:0] d;

    always_comb begin
        c = (car_x_i >= 10'(H_ACTIVE)) ? 11'd0 : {1'b0, car_x_i};
        if ({1'b0, x_i} >= c) begin
            d = {1'b0, x_i} - c;
        end else begin
            d = {1'b0, x_i} + 11'(H_ACTIVE) - c;
        end
        hit_o = (d < 11'(CAR_W)) && (row_off_i >= 9'(CAR_TOP)) && (row_off_i <= 9'(CAR_BOT));
    end

endmodule

// File: rtl/frogger_renderer.sv
// Two-stage pixel pipeline: lane decode, then sprite hit/colour; also latches one collision result per frame.
module frogger_renderer
    import frogger_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
    input  logic                    in_display,
    input  logic [9:0]              counter_x,
    input  logic [8:0]              counter_y,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic [NUM_ROAD*10-1:0]  car_x,
    input  logic [9:0]              frog_x,
    input  logic [2:0]              frog_lane,
    output logic [2:0]              pixel,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    collision,
    output logic                    frame_done
);

    lane_t       lane_d;
    logic [8:0]  row_off_d;
    logic [9:0]  car_sel_d;
    logic        boundary_d;

    lane_t       lane_p1_q;
    logic [8:0]  row_off_p1_q;
    logic [9:0]  x_p1_q;
    logic [9:0]  car_p1_q;
    logic [9:0]  frog_x_p1_q;
    lane_t       frog_lane_p1_q;
    logic        disp_p1_q;
    logic        hs_p1_q;
    logic        vs_p1_q;

    logic        lane_hit;
    logic        car_hit_d;
    logic        frog_hit_d;
    logic        hit_d;
    logic [2:0]  pixel_d;

    logic [2:0]  pixel_q;
    logic        hs_q;
    logic        vs_q;
    logic        collision_q;
    logic        frame_done_q;
    logic        flag_q;

    // Stage 1: lane decode by descending comparator chain, lowest matching lane wins.
    always_comb begin
        lane_d    = lane_t'(NUM_LANES - 1);
        row_off_d = counter_y - 9'((NUM_LANES - 1) * LANE_H);
        for (int l = NUM_LANES - 2; l >= 0; l--) begin
            if (counter_y < 9'((l + 1) * LANE_H)) begin
                lane_d    = lane_t'(l);
                row_off_d = counter_y - 9'(l * LANE_H);
            end
        end
        car_sel_d = '0;
        for (int l = 1; l <= NUM_ROAD; l++) begin
            if (lane_d == lane_t'(l)) begin
                car_sel_d = car_x[(l-1)*10 +: 10];
            end
        end
        boundary_d = (counter_x == 10'd0) && (counter_y == 9'(V_ACTIVE));
    end

    lane_car_hit u_car_hit (
        .x_i       (x_p1_q),
        .car_x_i   (car_p1_q),
        .row_off_i (row_off_p1_q),
        .hit_o     (lane_hit)
    );

    // Stage 2: sprite tests and colour priority.
    always_comb begin
        car_hit_d  = is_road(lane_p1_q) && lane_hit;
        frog_hit_d = (lane_p1_q == frog_lane_p1_q)
                  && ({1'b0, x_p1_q} >= {1'b0, frog_x_p1_q})
                  && ({1'b0, x_p1_q} <  ({1'b0, frog_x_p1_q} + 11'(FROG_W)))
                  && (row_off_p1_q >= 9'(FROG_TOP)) && (row_off_p1_q <= 9'(FROG_BOT));
        hit_d      = disp_p1_q && frog_hit_d && car_hit_d;
        pixel_d    = COL_ROAD;
        if (disp_p1_q) begin
            if (frog_hit_d)                pixel_d = COL_FROG;
            else if (car_hit_d)            pixel_d = COL_CAR;
            else if (!is_road(lane_p1_q))  pixel_d = COL_SAFE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_p1_q      <= '0;
            row_off_p1_q   <= '0;
            x_p1_q         <= '0;
            car_p1_q       <= '0;
            frog_x_p1_q    <= '0;
            frog_lane_p1_q <= '0;
            disp_p1_q      <= 1'b0;
            hs_p1_q        <= 1'b1;
            vs_p1_q        <= 1'b1;
            pixel_q        <= COL_ROAD;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            collision_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            flag_q         <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (pix_en) begin
                lane_p1_q      <= lane_d;
                row_off_p1_q   <= row_off_d;
                x_p1_q         <= counter_x;
                car_p1_q       <= car_sel_d;
                frog_x_p1_q    <= frog_x;
                frog_lane_p1_q <= frog_lane;
                disp_p1_q      <= in_display;
                hs_p1_q        <= hsync_in;
                vs_p1_q        <= vsync_in;
                pixel_q        <= pixel_d;
                hs_q           <= hs_p1_q;
                vs_q           <= vs_p1_q;
                // A hit on the boundary tick itself still belongs to the closing frame.
                if (boundary_d) begin
                    collision_q  <= flag_q | hit_d;
                    flag_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                end else if (hit_d) begin
                    flag_q <= 1'b1;
                end
            end
        end
    end

    assign pixel      = pixel_q;
    assign hsync_out  = hs_q;
    assign vsync_out  = vs_q;
    assign collision  = collision_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frogger_renderer.sv
// Randomized and directed bench for frogger_renderer against an arithmetic reference model.
module tb_frogger_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        in_display;
    logic [9:0]  counter_x;
    logic [8:0]  counter_y;
    logic        hsync_in;
    logic        vsync_in;
    logic [59:0] car_x;
    logic [9:0]  frog_x;
    logic [2:0]  frog_lane;
    logic [2:0]  pixel;
    logic        hsync_out;
    logic        vsync_out;
    logic        collision;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        ind;
        logic        hs;
        logic        vs;
        logic [59:0] car;
        logic [9:0]  fx;
        logic [2:0]  fl;
    } samp_t;

    samp_t      s1;
    logic [2:0] e_pix;
    logic       e_hs, e_vs, e_col, e_fd, flag;

    frogger_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .in_display (in_display),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .car_x      (car_x),
        .frog_x     (frog_x),
        .frog_lane  (frog_lane),
        .pixel      (pixel),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .collision  (collision),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: lane by division, car distance modulo the line width.
    function automatic void eval(input samp_t s, output logic [2:0] pix, output logic hit);
        int lane, roff, c, d, x;
        logic road, carh, frogh;
        x    = int'(s.x);
        lane = int'(s.y) / 60;
        if (lane > 7) lane = 7;
        roff = int'(s.y) - lane * 60;
        road = (lane >= 1) && (lane <= 6);
        c    = road ? (int'(s.car >> ((lane - 1) * 10)) & 1023) : 0;
        if (c >= 640) c = 0;
        d     = (x - c + 640) % 640;
        carh  = road && (d < 64) && (roff >= 10) && (roff <= 49);
        frogh = (lane == int'(s.fl)) && (x >= int'(s.fx)) && (x < int'(s.fx) + 32)
                && (roff >= 14) && (roff <= 45);
        if (!s.ind)     pix = 3'b000;
        else if (frogh) pix = 3'b110;
        else if (carh)  pix = 3'b100;
        else if (!road) pix = 3'b010;
        else            pix = 3'b000;
        hit = s.ind && frogh && carh;
    endfunction

    function automatic samp_t cur_samp();
        samp_t s;
        s.x = counter_x; s.y = counter_y; s.ind = in_display;
        s.hs = hsync_in; s.vs = vsync_in; s.car = car_x;
        s.fx = frog_x; s.fl = frog_lane;
        return s;
    endfunction

    task automatic model_reset();
        s1 = '0; s1.hs = 1'b1; s1.vs = 1'b1;
        e_pix = 3'b000; e_hs = 1'b1; e_vs = 1'b1;
        e_col = 1'b0; e_fd = 1'b0; flag = 1'b0;
    endtask

    task automatic model_tick();
        samp_t in_s;
        logic [2:0] p;
        logic h;
        in_s = cur_samp();
        eval(s1, p, h);
        e_pix = p; e_hs = s1.hs; e_vs = s1.vs;
        if (in_s.x == 10'd0 && in_s.y == 9'd480) begin
            e_col = flag | h; flag = 1'b0; e_fd = 1'b1;
        end else begin
            e_fd = 1'b0;
            if (h) flag = 1'b1;
        end
        s1 = in_s;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pixel"},      32'(pixel),      32'(e_pix));
        chk({tag, "_hsync"},      32'(hsync_out),  32'(e_hs));
        chk({tag, "_vsync"},      32'(vsync_out),  32'(e_vs));
        chk({tag, "_collision"},  32'(collision),  32'(e_col));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(e_fd));
    endtask

    // gap idle clocks with pix_en low, then one pix_en clock; entered and left at negedge.
    task automatic ptick(input int gap, input string tag);
        for (int i = 0; i < gap; i++) begin
            pix_en = 1'b0;
            @(posedge clk); #1;
            e_fd = 1'b0;
            check_all({tag, "_idle"});
            @(negedge clk);
        end
        pix_en = 1'b1;
        @(posedge clk); #1;
        model_tick();
        check_all(tag);
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic do_reset(input logic pe);
        rst = 1'b1; pix_en = pe;
        @(posedge clk); #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0; pix_en = 1'b0;
    endtask

    task automatic set_px(input int x, input int y, input logic ind);
        counter_x = 10'(x); counter_y = 9'(y); in_display = ind;
    endtask

    initial begin
        int xi, yi, ln;
        rst = 1'b0; pix_en = 1'b0; in_display = 1'b0;
        counter_x = '0; counter_y = '0; hsync_in = 1'b1; vsync_in = 1'b1;
        car_x = '0; frog_x = 10'd600; frog_lane = 3'd0;
        @(negedge clk);
        do_reset(1'b0);

        // Latency: red car pixel appears exactly two pix_en ticks later, syncs alike.
        car_x[0 +: 10] = 10'd80;
        set_px(100, 70, 1'b1); hsync_in = 1'b0; vsync_in = 1'b0;
        ptick(3, "lat1");
        chk("lat_first_tick_pixel", 32'(pixel), 32'h0);
        set_px(101, 70, 1'b1); hsync_in = 1'b1; vsync_in = 1'b1;
        ptick(3, "lat2");
        chk("lat_red", 32'(pixel), 32'h4);
        chk("lat_hsync_low", 32'(hsync_out), 32'h0);
        ptick(3, "lat3");
        chk("lat_hsync_back", 32'(hsync_out), 32'h1);

        // Wrap-around: car at 600 covers x=20 (d=60) but not x=24 (d=64).
        car_x[0 +: 10] = 10'd600;
        set_px(20, 100, 1'b1);  ptick(0, "wrap20");
        set_px(24, 100, 1'b1);  ptick(0, "wrap24");
        ptick(0, "wrap_a");
        chk("wrap_x20_red", 32'(s1.x == 10'd24 ? 3'b000 : 3'b111), 32'h0);
        chk("wrap_x24_road", 32'(pixel), 32'h0);

        // car_x=640 treated as 0 in lane 2, row margins.
        car_x[10 +: 10] = 10'd640;
        set_px(63, 135, 1'b1);  ptick(0, "c640_63");
        set_px(64, 135, 1'b1);  ptick(0, "c640_64");
        chk("c640_x63_red", 32'(pixel), 32'h4);
        set_px(10, 170, 1'b1);  ptick(0, "c640_row50");
        chk("c640_x64_road", 32'(pixel), 32'h0);
        ptick(0, "c640_b");
        chk("c640_row50_black", 32'(pixel), 32'h0);

        // Frog in the safe start lane.
        frog_lane = 3'd7; frog_x = 10'd300;
        set_px(310, 440, 1'b1); ptick(0, "safe_frog");
        set_px(340, 440, 1'b1); ptick(0, "safe_grass");
        chk("safe_frog_col", 32'(pixel), 32'h6);
        set_px(310, 440, 1'b0); ptick(0, "safe_blank");
        chk("safe_grass_col", 32'(pixel), 32'h2);
        ptick(0, "safe_c");
        chk("safe_blank_col", 32'(pixel), 32'h0);

        // Collision in lane 3 reported at the frame boundary, then a clean frame.
        frog_lane = 3'd3; frog_x = 10'd200; car_x[20 +: 10] = 10'd190;
        set_px(210, 200, 1'b1); ptick(1, "col_a");
        set_px(211, 200, 1'b1); ptick(1, "col_b");
        chk("col_frog_wins", 32'(pixel), 32'h6);
        set_px(0, 480, 1'b0);   ptick(1, "col_bnd");
        chk("col_reported", 32'(collision), 32'h1);
        chk("col_done_pulse", 32'(frame_done), 32'h1);
        car_x[20 +: 10] = 10'd500;
        set_px(210, 200, 1'b1); ptick(1, "clean_a");
        set_px(211, 200, 1'b1); ptick(1, "clean_b");
        set_px(0, 480, 1'b0);   ptick(1, "clean_bnd");
        chk("clean_reported", 32'(collision), 32'h0);

        // Reset mid-frame after a hit drops the sticky flag.
        car_x[20 +: 10] = 10'd190;
        set_px(210, 200, 1'b1); ptick(0, "rh_a");
        set_px(211, 200, 1'b1); ptick(0, "rh_b");
        set_px(5, 5, 1'b1);     ptick(0, "rh_c");
        do_reset(1'b1);
        chk("rst_pixel", 32'(pixel), 32'h0);
        set_px(0, 480, 1'b0);   ptick(0, "rh_bnd");
        chk("rst_lost_flag", 32'(collision), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h1);

        // Randomized traffic, biased toward overlaps and occasional frame boundaries.
        for (int n = 0; n < 800; n++) begin
            xi = $urandom_range(0, 639);
            yi = $urandom_range(0, 479);
            for (int l = 0; l < 6; l++) car_x[l*10 +: 10] = 10'($urandom_range(0, 1023));
            frog_x = 10'($urandom_range(0, 1023));
            frog_lane = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                ln = yi / 60;
                frog_lane = 3'(ln);
                frog_x = 10'((xi >= 40) ? xi - int'($urandom_range(0, 40)) : xi);
                if (ln >= 1 && ln <= 6)
                    car_x[(ln-1)*10 +: 10] = 10'((xi + 640 - int'($urandom_range(0, 80))) % 640);
            end
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) set_px(0, 480, 1'b0);
            else set_px(xi, yi, ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
            else ptick(int'($urandom_range(0, 3)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frogger_renderer.md
Name: frogger_renderer

Overview:
Pixel-generation stage between the game logic and the VGA pins. It takes the raster position and syncs from hvsync_generator, plus the car positions from the frogger module and the frog position from player logic. It produces the 3-bit RGB pixel, with hsync and vsync delayed to match the pixel. It also detects frog/car overlap during each frame and reports one collision result per frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
LANE_H, 60, lines per lane; lanes 0..7 fill V_ACTIVE
NUM_ROAD, 6, road lanes 1..6; lanes 0 (goal) and 7 (start) are safe
CAR_W, 64, car width in pixels
FROG_W, 32, frog width in pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel-rate enable (25 MHz tick); the pipeline advances only when this is 1
in_display  in  1  active-area flag from hvsync_generator
counter_x  in  10  raster X
counter_y  in  9  raster Y
hsync_in  in  1  active-low hsync from hvsync_generator
vsync_in  in  1  active-low vsync from hvsync_generator
car_x  in  NUM_ROAD*10  car X per road lane; lane L uses bits [(L-1)*10 +: 10]
frog_x  in  10  frog left edge
frog_lane  in  3  frog lane, 0..7
pixel  out  3  {R,G,B}
hsync_out  out  1  hsync_in delayed to align with pixel
vsync_out  out  1  vsync_in delayed to align with pixel
collision  out  1  result for the previous frame; held for one frame
frame_done  out  1  one-clk pulse when collision updates

Behaviour:
- Reset: pixel=0, hsync_out=1, vsync_out=1, collision=0, frame_done=0; sticky hit flag and all pipeline registers cleared. Reset wins over pix_en.
- Pipeline is 2 pix_en ticks deep. Stage 1 registers the inputs and computes lane (0..7) and row_off = y - lane*LANE_H. It uses a constant comparator chain, not a divider.
- Stage 2 computes car_hit, frog_hit and the final color. Output registers update on that same tick.
- hsync/vsync pass through 2 matching delay stages, so pixel, hsync_out and vsync_out stay mutually aligned.
- No state changes on clk edges where pix_en=0.
- Car wrap-around:
  - c = car_x of the lane; a value >= H_ACTIVE (e.g. 640) is treated as 0.
  - d = x - c if x >= c, else x + H_ACTIVE - c. Use 11-bit arithmetic, result < H_ACTIVE.
  - car_hit = road lane && d < CAR_W && 10 <= row_off <= 49.
- Frog: frog_hit = lane == frog_lane && frog_x <= x < frog_x + FROG_W (11-bit sum, no wrap) && 14 <= row_off <= 45.
- Color priority:
  - 000 if not in_display.
  - Otherwise frog 110, then car 100, then safe lane 010, then road 000.
- Collision:
  - Sticky hit flag is set on any stage-2 tick with in_display && frog_hit && car_hit.
  - Frame boundary is stage-1 input counter_x==0 && counter_y==V_ACTIVE with pix_en. On that tick: collision <= flag, flag <= 0, frame_done <= 1 for exactly one clk.
  - A stage-2 hit on the boundary tick is still captured in that frame.
- frog_lane 0 or 7 can never collide: no cars are drawn in safe lanes.
- Car/frog inputs are sampled per pixel. Inputs changing mid-frame take effect at the next pixel; no frame-locking.
- Reset asserted mid-frame: the flag is lost, and the next frame_done reports 0 unless a new hit occurs.

Decomposition:
- Package frogger_pkg holds:
  - Geometry constants: H_ACTIVE, V_ACTIVE, LANE_H, lane margins 10/49 and 14/45.
  - Color constants: COL_FROG=110, COL_CAR=100, COL_SAFE=010, COL_ROAD=000.
  - A lane-index typedef (3 bits).
- One natural sub-module: lane_car_hit. It is combinational and is given x, car_x and row_off; it returns the wrap-aware hit. It is instantiated once, muxed by lane.

Test Plan:
1. Reset, then x=100, y=70 (lane 1, row_off 10), car_x[lane1]=80, in_display=1, pix_en every 4th clk → pixel=100 exactly 2 pix_en ticks later; hsync/vsync edges equally delayed.
2. Car wrap: car_x=600, x=20, y=100 → d=60 → pixel=100; x=24 → d=64 → pixel=000 (road).
3. car_x=640 with x=0..63 in lane 2 → treated as 0, red for x<=63; y=135 (row_off 15) red, y=170 (row_off 50) black.
4. frog_lane=7, frog_x=300, y=440 (row_off 20), x=310 → 110; x=340 → 010 (safe); in_display=0 → 000.
5. frog_lane=3, frog_x=200, car_x[lane3]=190, one frame scanned → frame_done pulse at y=480, x=0 with collision=1. Next frame with car_x=500 → collision=0.
6. Assert rst for one clk mid-frame after a hit → outputs return to reset values; the next frame_done reports collision=0.
